// File: rtl/expu_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// expu_pipe_ctrl
//
// Valid/ready controller for the exponential-unit row datapath. It tracks
// which of the row's NUM_REGS pipeline stages hold valid data and drives the
// per-stage register enables and synchronous clear. It also carries a
// sideband tag in step with each operand. The controller has no arithmetic of
// its own; it sits beside the row and drives the row's enable/clear inputs.
//
// Parameters:
//   NUM_REGS   number of row pipeline stages (>= 1)
//   TAG_WIDTH  width of the sideband tag (>= 1)
//   CNT_WIDTH  width of the optional output-stall counter
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous reset, active low
//   clear_i      synchronous flush of all stages (beats every other event)
//   valid_i      upstream operand valid
//   ready_o      operand accepted this cycle
//   tag_i        tag accompanying the upstream operand
//   valid_o      result valid at the row output
//   ready_i      downstream accepts the result
//   tag_o        tag of the current result
//   enable_o     per-stage enables, bit k loads stage k+1
//   clear_o      clear to the row, a combinational copy of clear_i
//   busy_o       at least one stage holds valid data
//   stall_cnt_o  saturating count of cycles with valid_o & !ready_i
//
// Optional feature:
//   EXPU_PIPE_CTRL_STALL_CNT_EN  when defined, builds the stall counter;
//                                otherwise stall_cnt_o is tied to zero.
// ---------------------------------------------------------------------------
module expu_pipe_ctrl #(
  parameter int unsigned NUM_REGS  = 2,
  parameter int unsigned TAG_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [TAG_WIDTH-1:0] tag_o,
  output logic [NUM_REGS-1:0]  enable_o,
  output logic                 clear_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  localparam int N = int'(NUM_REGS);

  generate
    if (NUM_REGS < 1) begin : g_badNumRegs
      $error("expu_pipe_ctrl: NUM_REGS must be at least 1");
    end
    if (TAG_WIDTH < 1) begin : g_badTagWidth
      $error("expu_pipe_ctrl: TAG_WIDTH must be at least 1");
    end
  endgenerate

  // Index k here is stage k+1 in the row's numbering.
  logic [N-1:0]         r_valid;
  logic [TAG_WIDTH-1:0] r_tag [N];

  logic [N-1:0]         w_rdy;
  logic [N-1:0]         w_pv;
  logic [TAG_WIDTH-1:0] w_tagIn [N];
  logic [N-1:0]         w_en;

  // Ready ripples back from the output: a stage can take new data if it is
  // empty or if its current content moves on this cycle. The chain is kept
  // in a local accumulator so the vector is never read in its own block.
  always_comb begin
    logic rdyAcc;
    rdyAcc = ready_i;
    w_rdy  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      rdyAcc   = ~r_valid[k] | rdyAcc;
      w_rdy[k] = rdyAcc;
    end
  end

  // What each stage would receive: stage 1 is fed from upstream, every
  // later stage from the stage in front of it.
  always_comb begin
    w_pv       = '0;
    w_pv[0]    = valid_i;
    w_tagIn    = '{default: '0};
    w_tagIn[0] = tag_i;
    for (int k = 1; k < N; k++) begin
      w_pv[k]    = r_valid[k-1];
      w_tagIn[k] = r_tag[k-1];
    end
  end

  // Enables fire only when real data enters a stage, so bubbles leave the
  // row's data registers (and our tags) untouched.
  assign w_en = w_rdy & w_pv & {N{~clear_i}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      for (int k = 0; k < N; k++) r_tag[k] <= '0;
    end else if (clear_i) begin
      r_valid <= '0;
      for (int k = 0; k < N; k++) r_tag[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w_rdy[k]) r_valid[k] <= w_pv[k];
        if (w_en[k])  r_tag[k]   <= w_tagIn[k];
      end
    end
  end

  assign ready_o  = w_rdy[0] & ~clear_i;
  assign valid_o  = r_valid[N-1] & ~clear_i;
  assign tag_o    = r_tag[N-1];
  assign enable_o = w_en;
  assign clear_o  = clear_i;
  assign busy_o   = |r_valid;

`ifdef EXPU_PIPE_CTRL_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] r_stallCnt;
  logic                 w_stall;

  // valid_o is already masked by clear_i, and clear is checked first, so a
  // flush always wins over a stall increment.
  assign w_stall = valid_o & ~ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stallCnt <= '0;
    end else if (clear_i) begin
      r_stallCnt <= '0;
    end else if (w_stall && (r_stallCnt != '1)) begin
      r_stallCnt <= r_stallCnt + CNT_WIDTH'(1);
    end
  end

  assign stall_cnt_o = r_stallCnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
